// File: rtl/rv32_decode_stage.sv
// RV32I decode stage: splits fetched instructions into registered field beats.
// An output register plus a skid register keep in_ready a pure flop output.

package rv32;

  typedef logic [31:0] rv32_inst_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    rv32_inst_t  inst;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] funct12;
    logic [31:0] imm;
    logic        decode_error;
  } rv32_fields_t;

endpackage

module rv32_decode_stage #(
  parameter int unsigned PC_WIDTH     = 32,
  parameter bit          STRICT_FUNCT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PC_WIDTH-1:0]  in_pc,
  input  rv32::rv32_inst_t     in_inst,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_WIDTH-1:0]  out_pc,
  output rv32::rv32_fields_t   out_fields
);

  import rv32::*;

  function automatic rv32_fields_t decode_inst(input rv32_inst_t inst);
    rv32_fields_t f;
    logic         known;
    logic         funct_bad;
    logic         zero_rd;
    logic         zero_rs1;
    logic         keep_rs2;
    logic [31:0]  imm;
    f           = '0;
    f.inst      = inst;
    f.opcode    = inst[6:0];
    f.funct3    = inst[14:12];
    f.funct7    = inst[31:25];
    f.funct12   = inst[31:20];
    known       = 1'b1;
    funct_bad   = 1'b0;
    zero_rd     = 1'b0;
    zero_rs1    = 1'b0;
    keep_rs2    = 1'b0;
    imm         = 32'd0;
    case (inst[6:0])
      OPC_LUI, OPC_AUIPC: begin
        imm      = {inst[31:12], 12'd0};
        zero_rs1 = 1'b1;
      end
      OPC_JAL: begin
        imm      = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        zero_rs1 = 1'b1;
      end
      OPC_JALR: begin
        imm       = {{20{inst[31]}}, inst[31:20]};
        funct_bad = (inst[14:12] != 3'd0);
      end
      OPC_BRANCH: begin
        imm       = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        zero_rd   = 1'b1;
        keep_rs2  = 1'b1;
        funct_bad = (inst[14:12] == 3'd2) || (inst[14:12] == 3'd3);
      end
      OPC_LOAD: begin
        imm       = {{20{inst[31]}}, inst[31:20]};
        funct_bad = (inst[14:12] == 3'd3) || (inst[14:12] == 3'd6) || (inst[14:12] == 3'd7);
      end
      OPC_STORE: begin
        imm       = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        zero_rd   = 1'b1;
        keep_rs2  = 1'b1;
        funct_bad = (inst[14:12] > 3'd2);
      end
      OPC_OPIMM, OPC_SYSTEM: begin
        imm = {{20{inst[31]}}, inst[31:20]};
      end
      OPC_OP: begin
        keep_rs2 = 1'b1;
      end
      OPC_MISC: begin
        imm = 32'd0;
      end
      default: begin
        known = 1'b0;
      end
    endcase
    f.decode_error = (inst[1:0] != 2'b11) || !known || (STRICT_FUNCT && funct_bad);
    // A bad encoding keeps its raw register fields so a trap handler can see them.
    if (f.decode_error) begin
      f.imm = 32'd0;
      f.rd  = inst[11:7];
      f.rs1 = inst[19:15];
      f.rs2 = inst[24:20];
    end else begin
      f.imm = imm;
      f.rd  = zero_rd  ? 5'd0 : inst[11:7];
      f.rs1 = zero_rs1 ? 5'd0 : inst[19:15];
      f.rs2 = keep_rs2 ? inst[24:20] : 5'd0;
    end
    return f;
  endfunction

  logic                or_valid_q, or_valid_d;
  logic [PC_WIDTH-1:0] or_pc_q, or_pc_d;
  rv32_fields_t        or_fields_q, or_fields_d;
  logic                sk_valid_q, sk_valid_d;
  logic [PC_WIDTH-1:0] sk_pc_q, sk_pc_d;
  rv32_fields_t        sk_fields_q, sk_fields_d;
  logic                in_ready_q, in_ready_d;
  rv32_fields_t        in_dec;
  logic                in_fire;

  assign in_dec  = decode_inst(in_inst);
  assign in_fire = in_valid && in_ready_q;

  // Next-state for the output and skid registers; flush overrides everything.
  always_comb begin
    or_valid_d  = or_valid_q;
    or_pc_d     = or_pc_q;
    or_fields_d = or_fields_q;
    sk_valid_d  = sk_valid_q;
    sk_pc_d     = sk_pc_q;
    sk_fields_d = sk_fields_q;
    if (flush) begin
      or_valid_d = 1'b0;
      sk_valid_d = 1'b0;
    end else if (!or_valid_q || out_ready) begin
      if (sk_valid_q) begin
        or_valid_d  = 1'b1;
        or_pc_d     = sk_pc_q;
        or_fields_d = sk_fields_q;
        sk_valid_d  = 1'b0;
      end else if (in_fire) begin
        or_valid_d  = 1'b1;
        or_pc_d     = in_pc;
        or_fields_d = in_dec;
      end else begin
        or_valid_d  = 1'b0;
      end
    end else if (in_fire) begin
      sk_valid_d  = 1'b1;
      sk_pc_d     = in_pc;
      sk_fields_d = in_dec;
    end else begin
      sk_valid_d  = sk_valid_q;
    end
    in_ready_d = !sk_valid_d;
  end

  // State registers; in_ready stays low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_valid_q  <= 1'b0;
      or_pc_q     <= '0;
      or_fields_q <= '0;
      sk_valid_q  <= 1'b0;
      sk_pc_q     <= '0;
      sk_fields_q <= '0;
      in_ready_q  <= 1'b0;
    end else begin
      or_valid_q  <= or_valid_d;
      or_pc_q     <= or_pc_d;
      or_fields_q <= or_fields_d;
      sk_valid_q  <= sk_valid_d;
      sk_pc_q     <= sk_pc_d;
      sk_fields_q <= sk_fields_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = or_valid_q;
  assign out_pc     = or_pc_q;
  assign out_fields = or_fields_q;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Directed bench for rv32_decode_stage: decode table plus stall, flush and reset sequences.

module tb_rv32_decode_stage;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               flush;
  logic               in_valid;
  logic               in_ready, ns_in_ready;
  logic [31:0]        in_pc;
  logic [31:0]        in_inst;
  logic               out_valid, ns_out_valid;
  logic               out_ready;
  logic [31:0]        out_pc, ns_out_pc;
  rv32::rv32_fields_t out_fields, ns_out_fields;

  int checks = 0;
  int errors = 0;

  rv32_decode_stage #(.PC_WIDTH(32), .STRICT_FUNCT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_fields(out_fields)
  );

  rv32_decode_stage #(.PC_WIDTH(32), .STRICT_FUNCT(1'b0)) dut_ns (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ns_in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(ns_out_valid), .out_ready(out_ready),
    .out_pc(ns_out_pc), .out_fields(ns_out_fields)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic        err;
    logic        ns_err;
    logic [31:0] ns_imm;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    in_valid = v;
    in_pc    = pc;
    in_inst  = inst;
  endtask

  initial begin
    //           inst          opc    rd     rs1    rs2    f3    imm            err   ns_err ns_imm
    vecs[0]  = '{32'h00510093, 7'h13, 5'd1,  5'd2, 5'd0, 3'd0, 32'h00000005, 1'b0, 1'b0, 32'h00000005};
    vecs[1]  = '{32'hFE512E23, 7'h23, 5'd0,  5'd2, 5'd5, 3'd2, 32'hFFFFFFFC, 1'b0, 1'b0, 32'hFFFFFFFC};
    vecs[2]  = '{32'h123451B7, 7'h37, 5'd3,  5'd0, 5'd0, 3'd5, 32'h12345000, 1'b0, 1'b0, 32'h12345000};
    vecs[3]  = '{32'h00000000, 7'h00, 5'd0,  5'd0, 5'd0, 3'd0, 32'h00000000, 1'b1, 1'b1, 32'h00000000};
    vecs[4]  = '{32'h008110E7, 7'h67, 5'd1,  5'd2, 5'd8, 3'd1, 32'h00000000, 1'b1, 1'b0, 32'h00000008};
    vecs[5]  = '{32'hFE208CE3, 7'h63, 5'd0,  5'd1, 5'd2, 3'd0, 32'hFFFFFFF8, 1'b0, 1'b0, 32'hFFFFFFF8};
    vecs[6]  = '{32'h001000EF, 7'h6F, 5'd1,  5'd0, 5'd0, 3'd0, 32'h00000800, 1'b0, 1'b0, 32'h00000800};
    vecs[7]  = '{32'hFFF32283, 7'h03, 5'd5,  5'd6, 5'd0, 3'd2, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFF};
    vecs[8]  = '{32'h00033283, 7'h03, 5'd5,  5'd6, 5'd0, 3'd3, 32'h00000000, 1'b1, 1'b0, 32'h00000000};
    vecs[9]  = '{32'h002081B3, 7'h33, 5'd3,  5'd1, 5'd2, 3'd0, 32'h00000000, 1'b0, 1'b0, 32'h00000000};
    vecs[10] = '{32'h00510091, 7'h11, 5'd1,  5'd2, 5'd5, 3'd0, 32'h00000000, 1'b1, 1'b1, 32'h00000000};
    vecs[11] = '{32'hFFFFF517, 7'h17, 5'd10, 5'd0, 5'd0, 3'd7, 32'hFFFFF000, 1'b0, 1'b0, 32'hFFFFF000};
    vecs[12] = '{32'hFE20ACE3, 7'h63, 5'd25, 5'd1, 5'd2, 3'd2, 32'h00000000, 1'b1, 1'b0, 32'hFFFFFFF8};
    vecs[13] = '{32'hFE513E23, 7'h23, 5'd28, 5'd2, 5'd5, 3'd3, 32'h00000000, 1'b1, 1'b0, 32'hFFFFFFFC};
    vecs[14] = '{32'h00000073, 7'h73, 5'd0,  5'd0, 5'd0, 3'd0, 32'h00000000, 1'b0, 1'b0, 32'h00000000};
    vecs[15] = '{32'h0FF0000F, 7'h0F, 5'd0,  5'd0, 5'd0, 3'd0, 32'h00000000, 1'b0, 1'b0, 32'h00000000};
    vecs[16] = '{32'h0000007F, 7'h7F, 5'd0,  5'd0, 5'd0, 3'd0, 32'h00000000, 1'b1, 1'b1, 32'h00000000};

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'd0, 32'd0);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_fields", out_fields, 109'd0);
    tick();
    tick();
    chk("rst_hold_in_ready", in_ready, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_out_valid", out_valid, 1'b0);

    // Streaming decode table, one beat per cycle.
    for (int i = 0; i < NVEC; i++) begin
      drive(1'b1, 32'h1000 + 32'(i) * 32'd4, vecs[i].inst);
      tick();
      chk("tbl_out_valid", out_valid, 1'b1);
      chk("tbl_in_ready", in_ready, 1'b1);
      chk("tbl_pc", out_pc, 32'h1000 + 32'(i) * 32'd4);
      chk("tbl_inst", out_fields.inst, vecs[i].inst);
      chk("tbl_opcode", out_fields.opcode, vecs[i].opcode);
      chk("tbl_rd", out_fields.rd, vecs[i].rd);
      chk("tbl_rs1", out_fields.rs1, vecs[i].rs1);
      chk("tbl_rs2", out_fields.rs2, vecs[i].rs2);
      chk("tbl_funct3", out_fields.funct3, vecs[i].funct3);
      chk("tbl_funct7", out_fields.funct7, vecs[i].inst[31:25]);
      chk("tbl_imm", out_fields.imm, vecs[i].imm);
      chk("tbl_err", out_fields.decode_error, vecs[i].err);
      chk("tbl_ns_err", ns_out_fields.decode_error, vecs[i].ns_err);
      chk("tbl_ns_imm", ns_out_fields.imm, vecs[i].ns_imm);
    end
    drive(1'b0, 32'd0, 32'd0);
    tick();
    chk("drain_out_valid", out_valid, 1'b0);

    // Backpressure: two beats are held, the third waits for the skid to free.
    out_ready = 1'b0;
    drive(1'b1, 32'h0A00, 32'h00100093);
    tick();
    chk("bp1_out_valid", out_valid, 1'b1);
    chk("bp1_pc", out_pc, 32'h0A00);
    chk("bp1_in_ready", in_ready, 1'b1);
    drive(1'b1, 32'h0A04, 32'h00200093);
    tick();
    chk("bp2_pc_hold", out_pc, 32'h0A00);
    chk("bp2_in_ready", in_ready, 1'b0);
    drive(1'b1, 32'h0A08, 32'h00300093);
    tick();
    chk("bp3_pc_hold", out_pc, 32'h0A00);
    chk("bp3_imm_hold", out_fields.imm, 32'd1);
    chk("bp3_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    tick();
    chk("bp4_pc", out_pc, 32'h0A04);
    chk("bp4_imm", out_fields.imm, 32'd2);
    chk("bp4_in_ready", in_ready, 1'b1);
    tick();
    chk("bp5_pc", out_pc, 32'h0A08);
    chk("bp5_out_valid", out_valid, 1'b1);
    drive(1'b0, 32'd0, 32'd0);
    tick();
    chk("bp6_out_valid", out_valid, 1'b0);

    // Flush with both entries full and a third beat offered.
    out_ready = 1'b0;
    drive(1'b1, 32'h0D00, 32'h00100093);
    tick();
    drive(1'b1, 32'h0D04, 32'h00200093);
    tick();
    chk("fl_pre_in_ready", in_ready, 1'b0);
    drive(1'b1, 32'h0D08, 32'h00300093);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_out_valid", out_valid, 1'b0);
    chk("fl_in_ready", in_ready, 1'b1);
    drive(1'b0, 32'd0, 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("fl_no_emit", out_valid, 1'b0);
    end

    // Asynchronous reset in the middle of a stream.
    drive(1'b1, 32'h0B00, 32'h00100093);
    tick();
    drive(1'b1, 32'h0B04, 32'h00200093);
    tick();
    chk("mr_pre_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mr_out_valid", out_valid, 1'b0);
    chk("mr_out_pc", out_pc, 32'd0);
    chk("mr_fields", out_fields, 109'd0);
    chk("mr_in_ready", in_ready, 1'b0);
    tick();
    tick();
    drive(1'b1, 32'h0C00, 32'h00700093);
    rst_n = 1'b1;
    tick();
    chk("mr_rel_in_ready", in_ready, 1'b1);
    chk("mr_rel_out_valid", out_valid, 1'b0);
    tick();
    chk("mr_first_valid", out_valid, 1'b1);
    chk("mr_first_pc", out_pc, 32'h0C00);
    chk("mr_first_imm", out_fields.imm, 32'd7);
    drive(1'b0, 32'd0, 32'd0);
    tick();
    chk("mr_end_valid", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
